rv32m_div: RTL and testbench

RV32M_DIV -- requirements
Module: rv32m_div

---
 rtl/rv32m_div_pkg.sv | 21 ++
 rtl/rv32m_div.sv | 146 ++++++++++++++
 tb/tb_rv32m_div.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rv32m_div_pkg.sv
// Shared definitions for the RV32M divider: operand width and div_op encodings.
package rv32m_div_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } divOp_t;

    function automatic logic isSignedOp(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic isRemOp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/rv32m_div.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on magnitudes, with sign fix-up applied to the registered result.
module rv32m_div
    import rv32m_div_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_start,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] div_s1,
    input  logic [DATA_WIDTH-1:0] div_s2,
    output logic                  div_ready,
    output logic [DATA_WIDTH-1:0] div_result,
    output logic                  div_busy
);

    localparam logic [5:0]            LAST_STEP = 6'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_INT   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                r_state;
    logic                  r_isRem;
    logic                  r_negQuo;
    logic                  r_negRem;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [5:0]            r_cnt;
    logic                  r_ready;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_s1Neg;
    logic                  w_s2Neg;
    logic [DATA_WIDTH-1:0] w_absS1;
    logic [DATA_WIDTH-1:0] w_absS2;
    logic                  w_divZero;
    logic                  w_overflow;
    logic [DATA_WIDTH-1:0] w_specialResult;
    logic [DATA_WIDTH:0]   w_shifted;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_qBit;
    logic [DATA_WIDTH-1:0] w_nextRem;
    logic [DATA_WIDTH-1:0] w_nextQuo;
    logic [DATA_WIDTH-1:0] w_quoFinal;
    logic [DATA_WIDTH-1:0] w_remFinal;
    logic [DATA_WIDTH-1:0] w_calcResult;

    // Operand pre-processing: magnitudes and signs are only meaningful for signed ops.
    assign w_s1Neg    = isSignedOp(div_op) & div_s1[DATA_WIDTH-1];
    assign w_s2Neg    = isSignedOp(div_op) & div_s2[DATA_WIDTH-1];
    assign w_absS1    = w_s1Neg ? -div_s1 : div_s1;
    assign w_absS2    = w_s2Neg ? -div_s2 : div_s2;
    assign w_divZero  = (div_s2 == '0);
    assign w_overflow = isSignedOp(div_op) && (div_s1 == MIN_INT) && (div_s2 == '1);

    assign w_specialResult = w_divZero ? (isRemOp(div_op) ? div_s1 : '1)
                                       : (isRemOp(div_op) ? '0 : MIN_INT);

    // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
    assign w_shifted = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_qBit    = ~w_trial[DATA_WIDTH];
    assign w_nextRem = w_qBit ? w_trial[DATA_WIDTH-1:0] : w_shifted[DATA_WIDTH-1:0];
    assign w_nextQuo = {r_quo[DATA_WIDTH-2:0], w_qBit};

    assign w_quoFinal   = r_negQuo ? -w_nextQuo : w_nextQuo;
    assign w_remFinal   = r_negRem ? -w_nextRem : w_nextRem;
    assign w_calcResult = r_isRem ? w_remFinal : w_quoFinal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_isRem   <= 1'b0;
            r_negQuo  <= 1'b0;
            r_negRem  <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (div_start) begin
                        r_isRem   <= isRemOp(div_op);
                        r_negQuo  <= w_s1Neg ^ w_s2Neg;
                        r_negRem  <= w_s1Neg;
                        r_rem     <= '0;
                        r_quo     <= w_absS1;
                        r_divisor <= w_absS2;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (w_divZero || w_overflow) begin
                            r_state  <= DONE;
                            r_result <= w_specialResult;
                            r_ready  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A dropped request means the issuing lane was flushed.
                    if (!div_start) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_nextRem;
                        r_quo <= w_nextQuo;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == LAST_STEP) begin
                            r_state  <= DONE;
                            r_result <= w_calcResult;
                            r_ready  <= 1'b1;
                            r_cnt    <= '0;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign div_ready  = r_ready;
    assign div_busy   = r_busy;
    assign div_result = r_result;

endmodule

// File: tb/tb_rv32m_div.sv
// Self-checking bench for rv32m_div: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_rv32m_div;
    import rv32m_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] div_s1;
    logic [31:0] div_s2;
    logic        div_ready;
    logic [31:0] div_result;
    logic        div_busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] lastExpected = '0;

    always #5 clk = ~clk;

    rv32m_div #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_start  (div_start),
        .div_op     (div_op),
        .div_s1     (div_s1),
        .div_s2     (div_s2),
        .div_ready  (div_ready),
        .div_result (div_result),
        .div_busy   (div_busy)
    );

    function automatic logic isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M division semantics written directly as integer arithmetic.
    function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0)
            return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
        if (isSpecial(op, a, b))
            return (op == OP_REM) ? 32'd0 : 32'h8000_0000;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_REM:  return 32'(sa % sb);
            OP_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge with the divider idle; returns one idle cycle after completion.
    task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cycle;
        int          expLatency;
        logic [31:0] expected;
        expected   = refDiv(op, a, b);
        expLatency = isSpecial(op, a, b) ? 2 : 34;
        div_op    = op;
        div_s1    = a;
        div_s2    = b;
        div_start = 1'b1;
        cycle     = 1;
        while (cycle < 40) begin
            @(negedge clk);
            cycle++;
            div_s1 = $urandom;
            div_s2 = $urandom;
            div_op = 2'($urandom_range(0, 3));
            if (div_ready) break;
        end
        checkOutput({tag, "/latency"}, 32'(cycle), 32'(expLatency));
        checkOutput({tag, "/result"}, div_result, expected);
        checkOutput({tag, "/busyInDone"}, {31'd0, div_busy}, 32'd1);
        div_start = 1'b0;
        @(negedge clk);
        checkOutput({tag, "/afterDone"}, {30'd0, div_ready, div_busy}, 32'd0);
        checkOutput({tag, "/hold"}, div_result, expected);
        lastExpected = expected;
    endtask

    initial begin
        logic        sawReady;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst_n     = 1'b0;
        div_start = 1'b0;
        div_op    = OP_DIV;
        div_s1    = '0;
        div_s2    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset/flags", {30'd0, div_ready, div_busy}, 32'd0);
        checkOutput("reset/result", div_result, 32'd0);

        rst_n = 1'b1;
        applyStimulus("divu100_7", OP_DIVU, 32'd100, 32'd7);
        applyStimulus("remu100_7", OP_REMU, 32'd100, 32'd7);
        applyStimulus("divNeg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("remNeg7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        applyStimulus("div5_0", OP_DIV, 32'd5, 32'd0);
        applyStimulus("remu5_0", OP_REMU, 32'd5, 32'd0);
        applyStimulus("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("remOvf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in cycle 10 of a long divide.
        div_op    = OP_DIVU;
        div_s1    = 32'd1000;
        div_s2    = 32'd3;
        div_start = 1'b1;
        sawReady  = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            sawReady |= div_ready;
        end
        div_start = 1'b0;
        @(negedge clk);
        checkOutput("abort/flags", {29'd0, sawReady, div_ready, div_busy}, 32'd0);
        checkOutput("abort/result", div_result, lastExpected);
        applyStimulus("divu9_3", OP_DIVU, 32'd9, 32'd3);

        // Reset in cycle 20 of a divide, with the request still held.
        div_op    = OP_DIVU;
        div_s1    = 32'd1000;
        div_s2    = 32'd3;
        div_start = 1'b1;
        for (int c = 2; c <= 20; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midReset/flags", {30'd0, div_ready, div_busy}, 32'd0);
        checkOutput("midReset/result", div_result, 32'd0);
        rst_n = 1'b1;
        applyStimulus("divu8_2", OP_DIVU, 32'd8, 32'd2);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                b = $urandom_range(1, 15);
            end else if (sel == 3) begin
                b = -32'($urandom_range(1, 15));
            end
            applyStimulus($sformatf("rand%0d", i), op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
